acc_control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU; sits directly upstream of the ALU.
- Holds PC, IR, MDR, ACC and the Z/C flag register.
- Drives the ALU operands and op code, and registers the ALU result and flags.
- Talks to unified program/data memory over a req/ack handshake.

---
 rtl/acc_control_unit_if.sv | 21 ++
 rtl/acc_control_unit.sv | 173 +++++++++++++++++
 tb/tb_acc_control_unit.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_control_unit_if.sv
// Memory-side req/ack bus of the accumulator CPU sequencer.
interface acc_control_unit_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/acc_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Holds PC/IR/MDR/ACC and Z/C flags, drives the ALU and the memory bus.
module acc_control_unit #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  acc_control_unit_if.master mem,
  output logic [7:0]         alu_x_o,
  output logic [7:0]         alu_y_o,
  output logic [2:0]         alu_op_o,
  input  logic [7:0]         alu_r_i,
  input  logic               alu_fz_i,
  input  logic               alu_fc_i,
  output logic [7:0]         acc_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               fz_o,
  output logic               fc_o,
  output logic               halted_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_LD  = 3'd1;
  localparam logic [OP_W-1:0] OP_ST  = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB = 3'd4;
  localparam logic [OP_W-1:0] OP_JMP = 3'd5;
  localparam logic [OP_W-1:0] OP_JZ  = 3'd6;
  localparam logic [OP_W-1:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_READ, S_EXEC, S_WRITE, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                fz_q, fz_d;
  logic                fc_q, fc_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                halted_q, halted_d;

  logic [OP_W-1:0]     ir_op;
  logic [ADDR_W-1:0]   ir_addr;
  logic                mem_hs;

  assign ir_op   = ir_q[DATA_W-1 -: OP_W];
  assign ir_addr = ir_q[ADDR_W-1:0];
  // A transfer completes only on an ack while our request is actually up.
  assign mem_hs  = req_q & mem.mem_ack_i;

  // State and datapath registers; bus outputs are registered from next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      pc_q     <= ADDR_W'(RESET_PC);
      ir_q     <= '0;
      mdr_q    <= '0;
      acc_q    <= '0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      acc_q    <= acc_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
    end
  end

  // Next-state, datapath updates and next bus drive.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    acc_d   = acc_q;
    fz_d    = fz_q;
    fc_d    = fc_q;

    case (state_q)
      S_FETCH: begin
        if (mem_hs) begin
          ir_d    = mem.mem_rdata_i;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_op)
          OP_NOP:                 state_d = S_FETCH;
          OP_LD, OP_ADD, OP_SUB:  state_d = S_READ;
          OP_ST:                  state_d = S_WRITE;
          OP_JMP: begin
            pc_d    = ir_addr;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (fz_q) pc_d = ir_addr;
            state_d = S_FETCH;
          end
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = S_FETCH;
        endcase
      end
      S_READ: begin
        if (mem_hs) begin
          mdr_d   = mem.mem_rdata_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (ir_op)
          OP_LD: begin
            acc_d = mdr_q;
            fz_d  = (mdr_q == '0);
          end
          OP_ADD, OP_SUB: begin
            acc_d = alu_r_i;
            fz_d  = alu_fz_i;
            fc_d  = alu_fc_i;
          end
          default: ;
        endcase
        state_d = S_FETCH;
      end
      S_WRITE: begin
        if (mem_hs) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    req_d    = (state_d == S_FETCH) || (state_d == S_READ) || (state_d == S_WRITE);
    we_d     = (state_d == S_WRITE);
    addr_d   = (state_d == S_FETCH) ? pc_d : ir_d[ADDR_W-1:0];
    halted_d = (state_d == S_HALT);
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = acc_q;

  assign alu_x_o  = acc_q;
  assign alu_y_o  = mdr_q;
  assign alu_op_o = (ir_op == OP_SUB) ? 3'b001 : 3'b000;

  assign acc_o    = acc_q;
  assign pc_o     = pc_q;
  assign fz_o     = fz_q;
  assign fc_o     = fc_q;
  assign halted_o = halted_q;

endmodule

// File: tb/tb_acc_control_unit.sv
// Scoreboard bench for acc_control_unit: ISA-level reference model predicts
// every memory transfer and the final architectural state of each program.
module tb_acc_control_unit;

  localparam int unsigned AW = 5;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          chk_op;
    logic [2:0]    op;
  } xfer_t;

  logic          clk;
  logic          rst_n;
  logic [7:0]    alu_x, alu_y, alu_r;
  logic [2:0]    alu_op;
  logic          alu_fz, alu_fc;
  logic [7:0]    acc;
  logic [AW-1:0] pc;
  logic          fz, fc, halted;

  acc_control_unit_if #(.ADDR_W(AW)) mem_if ();

  acc_control_unit #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .mem      (mem_if),
    .alu_x_o  (alu_x),
    .alu_y_o  (alu_y),
    .alu_op_o (alu_op),
    .alu_r_i  (alu_r),
    .alu_fz_i (alu_fz),
    .alu_fc_i (alu_fc),
    .acc_o    (acc),
    .pc_o     (pc),
    .fz_o     (fz),
    .fc_o     (fc),
    .halted_o (halted)
  );

  // Downstream ALU: 8-bit add, or subtract with borrow.
  always_comb begin
    if (alu_op == 3'b001) begin
      alu_r  = alu_x - alu_y;
      alu_fc = (alu_x < alu_y);
    end else begin
      {alu_fc, alu_r} = {1'b0, alu_x} + {1'b0, alu_y};
    end
    alu_fz = (alu_r == 8'h00);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  xfer_t       exp_q[$];
  logic [7:0]  prog_mem [32];
  logic [7:0]  mem      [32];
  logic [7:0]  exp_mem  [32];

  bit          sb_en, hold_ack, ack_in_reset, stray_en, fixed_wait;
  int unsigned max_wait;
  int          hs_cnt, lat, total_waits, halt_req_err, wcnt, cur_wait;
  bit          started, in_xfer, stable, exec_chk;
  logic [2:0]  exec_op;
  logic        h_we;
  logic [AW-1:0] h_addr;
  logic [7:0]  h_wdata;
  xfer_t       e_mon;

  logic [7:0]  m_acc;
  logic        m_fz, m_fc;
  logic [AW-1:0] m_pc;
  int          m_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [2:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  // Memory responder and scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] = prog_mem[i];
      mem_if.mem_ack_i   = ack_in_reset;
      mem_if.mem_rdata_i = 8'h00;
      in_xfer = 0; exec_chk = 0; started = 0;
      hs_cnt = 0; lat = 0; total_waits = 0; halt_req_err = 0;
    end else begin
      mem_if.mem_ack_i = 1'b0;
      if (exec_chk) begin
        exec_chk = 0;
        check($sformatf("xfer%0d.alu_op_exec", hs_cnt), 64'(alu_op), 64'(exec_op));
      end
      if (mem_if.mem_req_o) begin
        started = 1;
        if (!in_xfer) begin
          in_xfer = 1; stable = 1; wcnt = 0;
          h_we = mem_if.mem_we_o; h_addr = mem_if.mem_addr_o; h_wdata = mem_if.mem_wdata_o;
          cur_wait = fixed_wait ? int'(max_wait) : int'($urandom_range(0, max_wait));
        end else if (mem_if.mem_we_o !== h_we || mem_if.mem_addr_o !== h_addr ||
                     (h_we && mem_if.mem_wdata_o !== h_wdata)) begin
          stable = 0;
        end
        if (wcnt >= cur_wait && !(hold_ack && hs_cnt >= 1)) begin
          mem_if.mem_ack_i   = 1'b1;
          mem_if.mem_rdata_i = mem[mem_if.mem_addr_o];
          if (mem_if.mem_we_o) mem[mem_if.mem_addr_o] = mem_if.mem_wdata_o;
          in_xfer = 0;
          hs_cnt++;
          total_waits += wcnt;
          if (sb_en) begin
            check($sformatf("xfer%0d.expected", hs_cnt), 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e_mon = exp_q.pop_front();
              check($sformatf("xfer%0d.stable", hs_cnt), 64'(stable), 64'd1);
              check($sformatf("xfer%0d.bus", hs_cnt),
                    64'({mem_if.mem_we_o, mem_if.mem_addr_o, mem_if.mem_we_o ? mem_if.mem_wdata_o : 8'h00}),
                    64'({e_mon.we, e_mon.addr, e_mon.we ? e_mon.wdata : 8'h00}));
              if (e_mon.chk_op) begin
                check($sformatf("xfer%0d.alu_op_read", hs_cnt), 64'(alu_op), 64'(e_mon.op));
                exec_chk = 1;
                exec_op  = e_mon.op;
              end
            end
          end
        end else begin
          wcnt++;
        end
      end else if (stray_en) begin
        mem_if.mem_ack_i = ($urandom_range(0, 2) == 0);
      end
      if (started && !halted) lat++;
      if (halted && mem_if.mem_req_o) halt_req_err++;
    end
  end

  // Instruction-level reference: walks the program and queues expected transfers.
  task automatic run_model();
    logic [7:0]    mm [32];
    logic [7:0]    ir, m;
    logic [AW-1:0] p, a;
    logic [2:0]    op;
    logic [8:0]    sum;
    bit            done;
    xfer_t         e;
    for (int i = 0; i < 32; i++) mm[i] = prog_mem[i];
    m_acc = 8'h00; m_fz = 0; m_fc = 0; p = '0; m_base = 0; done = 0;
    for (int s = 0; s < 500 && !done; s++) begin
      ir = mm[p];
      e = '0; e.addr = p; exp_q.push_back(e);
      p  = p + 5'd1;
      op = ir[7:5];
      a  = ir[4:0];
      case (op)
        3'd1, 3'd3, 3'd4: begin
          e = '0; e.addr = a; e.chk_op = 1; e.op = (op == 3'd4) ? 3'd1 : 3'd0;
          exp_q.push_back(e);
          m = mm[a];
          m_base += 4;
          if (op == 3'd1) begin
            m_acc = m; m_fz = (m == 8'h00);
          end else if (op == 3'd3) begin
            sum = 9'(m_acc) + 9'(m);
            m_acc = sum[7:0]; m_fc = sum[8]; m_fz = (sum[7:0] == 8'h00);
          end else begin
            m_fc = (m_acc < m); m_acc = m_acc - m; m_fz = (m_acc == 8'h00);
          end
        end
        3'd2: begin
          e = '0; e.we = 1; e.addr = a; e.wdata = m_acc; exp_q.push_back(e);
          mm[a] = m_acc;
          m_base += 3;
        end
        3'd5: begin p = a; m_base += 2; end
        3'd6: begin if (m_fz) p = a; m_base += 2; end
        3'd7: begin done = 1; m_base += 2; end
        default: m_base += 2;
      endcase
    end
    m_pc = p;
    for (int i = 0; i < 32; i++) exp_mem[i] = mm[i];
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog_mem[i] = 8'h00;
  endtask

  task automatic run_prog(input string tag, input int unsigned mw, input bit fixed, input bit stray);
    int n;
    int bad;
    max_wait = mw; fixed_wait = fixed; stray_en = stray; ack_in_reset = stray;
    hold_ack = 0; sb_en = 1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    run_model();
    #1;
    check({tag, ".reset_out"},
          64'({mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_addr_o, mem_if.mem_wdata_o,
               alu_x, alu_y, alu_op, acc, pc, fz, fc, halted}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (!halted && n < 4000) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, ".halted"}, 64'(halted), 64'd1);
    repeat (6) @(posedge clk);
    #2;
    check({tag, ".queue_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, ".acc"}, 64'(acc), 64'(m_acc));
    check({tag, ".flags"}, 64'({fz, fc}), 64'({m_fz, m_fc}));
    check({tag, ".pc"}, 64'(pc), 64'(m_pc));
    check({tag, ".latency"}, 64'(lat), 64'(m_base + total_waits));
    check({tag, ".halt_no_req"}, 64'(halt_req_err), 64'd0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) bad++;
    check({tag, ".mem_words_wrong"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [4:0] a;
    int unsigned op;
    rst_n = 1'b0;
    sb_en = 0; hold_ack = 0; ack_in_reset = 0; stray_en = 0; fixed_wait = 1; max_wait = 0;
    clear_prog();

    // Abort a read in flight with reset; req must fall without a clock.
    prog_mem[0]  = enc(3'd1, 5'd10);
    prog_mem[1]  = enc(3'd7, 5'd0);
    prog_mem[10] = 8'h5A;
    hold_ack = 1; ack_in_reset = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (hs_cnt < 1 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check("abort.fetch_done", 64'(hs_cnt), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    check("abort.read_inflight", 64'({mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_addr_o}),
          64'({1'b1, 1'b0, 5'd10}));
    rst_n = 1'b0;
    #1;
    check("abort.req_drop", 64'({mem_if.mem_req_o, mem_if.mem_we_o}), 64'd0);
    check("abort.pc_reset", 64'(pc), 64'd0);

    // LD/ADD/ST/HLT, zero-wait.
    clear_prog();
    prog_mem[0] = enc(3'd1, 5'd10); prog_mem[1] = enc(3'd3, 5'd11);
    prog_mem[2] = enc(3'd2, 5'd12); prog_mem[3] = enc(3'd7, 5'd0);
    prog_mem[10] = 8'h05; prog_mem[11] = 8'h03;
    run_prog("add", 0, 1, 0);
    check("add.acc_const", 64'(acc), 64'h08);
    check("add.mem12_const", 64'(mem[12]), 64'h08);
    check("add.lat13", 64'(lat), 64'd13);

    // Same program with three wait states per transfer and stray acks.
    run_prog("wait3", 3, 1, 1);
    check("wait3.lat34", 64'(lat), 64'd34);

    // ADD overflow sets Z and C; JZ taken; LD keeps C; JZ falls through.
    clear_prog();
    prog_mem[0]  = enc(3'd1, 5'd10); prog_mem[1] = enc(3'd3, 5'd11);
    prog_mem[2]  = enc(3'd6, 5'd20);
    prog_mem[20] = enc(3'd1, 5'd13); prog_mem[21] = enc(3'd6, 5'd25);
    prog_mem[22] = enc(3'd7, 5'd0);  prog_mem[25] = enc(3'd7, 5'd0);
    prog_mem[10] = 8'hFF; prog_mem[11] = 8'h01; prog_mem[13] = 8'h01;
    run_prog("ovf", 0, 1, 0);
    check("ovf.pc_const", 64'(pc), 64'd23);
    check("ovf.flags_const", 64'({fz, fc}), 64'b01);

    // SUB with borrow.
    clear_prog();
    prog_mem[0] = enc(3'd1, 5'd10); prog_mem[1] = enc(3'd4, 5'd11);
    prog_mem[2] = enc(3'd7, 5'd0);
    prog_mem[10] = 8'h02; prog_mem[11] = 8'h03;
    run_prog("sub", 1, 0, 0);
    check("sub.acc_const", 64'(acc), 64'hFF);
    check("sub.flags_const", 64'({fz, fc}), 64'b01);

    // PC wrap from 31 to 0.
    clear_prog();
    prog_mem[0] = enc(3'd6, 5'd4);  prog_mem[1] = enc(3'd1, 5'd30);
    prog_mem[2] = enc(3'd5, 5'd31); prog_mem[4] = enc(3'd7, 5'd0);
    prog_mem[31] = enc(3'd0, 5'd0); prog_mem[30] = 8'h00;
    run_prog("wrap", 0, 1, 0);
    check("wrap.pc_const", 64'(pc), 64'd5);

    // Random forward-only programs with random waits and stray acks.
    for (int r = 0; r < 6; r++) begin
      clear_prog();
      for (int i = 0; i < 15; i++) begin
        op = $urandom_range(0, 6);
        if (op == 5 || op == 6) a = 5'($urandom_range(i + 1, 15));
        else                    a = 5'($urandom_range(16, 31));
        prog_mem[i] = {3'(op), a};
      end
      prog_mem[15] = enc(3'd7, 5'd0);
      for (int i = 16; i < 32; i++)
        prog_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run_prog($sformatf("rnd%0d", r), 3, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
